// File: rtl/imc_mac_scheduler.sv
// Wishbone-programmed sequencer for the SRAM in-memory-compute macro: loads weight
// rows, applies input vectors, waits a settle time and samples the sense amps per vector.
module imc_mac_scheduler #(
  parameter int ROWS = 16,
  localparam int AW = $clog2(ROWS)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  input  logic          wb_empty,
  input  logic          ib_empty,
  input  logic          sa_full,
  output logic          wb_pop,
  output logic          ib_pop,
  output logic          sa_sample,
  output logic          sram_we,
  output logic [AW-1:0] wl_addr,
  output logic          en_vclp,
  output logic          mac_starting,
  output logic [2:0]    ctrl_state,
  output logic          irq
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q;
  logic [AW-1:0] row_q;
  logic [7:0]    vec_q;
  logic [3:0]    settle_q;
  logic [5:0]    rows_lim_q;
  logic [3:0]    settle_lim_q;
  logic [7:0]    vecs_lim_q;
  logic [15:0]   mac_q;
  logic [4:0]    cfg_rows_q;
  logic [3:0]    cfg_settle_q;
  logic [7:0]    cfg_vecs_q;
  logic          done_q, ign_q, abt_q;
  logic          ack_q;
  logic [31:0]   dat_q;

  logic        wb_acc, wr_acc;
  logic [1:0]  reg_sel;
  logic        ctrl_wr, cfg_wr, stat_wr;
  logic        start_req, abort_req;
  logic [5:0]  rows_use;
  logic [3:0]  settle_use;
  logic [7:0]  vecs_use;
  logic        last_row;
  logic [7:0]  next_vec;
  logic        more_vecs;
  logic [31:0] rdata_d;
  logic        unused_bits;

  assign wb_acc    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_acc    = wb_acc & wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign ctrl_wr   = wr_acc && (reg_sel == 2'd0);
  assign cfg_wr    = wr_acc && (reg_sel == 2'd1);
  assign stat_wr   = wr_acc && (reg_sel == 2'd2);
  assign start_req = ctrl_wr & wbs_dat_i[0];
  assign abort_req = ctrl_wr & wbs_dat_i[3];

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:24],
                         wbs_dat_i[15:12], wbs_dat_i[7:5]};

  // Zero/out-of-range config fields fall back to safe values when a run starts.
  assign rows_use   = (cfg_rows_q == 5'd0 || {1'b0, cfg_rows_q} > 6'(ROWS)) ?
                      6'(ROWS) : {1'b0, cfg_rows_q};
  assign settle_use = (cfg_settle_q == 4'd0) ? 4'd1 : cfg_settle_q;
  assign vecs_use   = (cfg_vecs_q == 8'd0) ? 8'd1 : cfg_vecs_q;

  assign last_row  = (6'(row_q) == rows_lim_q - 6'd1);
  assign next_vec  = vec_q + 8'd1;
  assign more_vecs = (next_vec < vecs_lim_q);

  // Strobes follow the buffer flags in the same cycle; an abort write suppresses them.
  assign wb_pop       = (state_q == S_LOAD)   & ~wb_empty & ~abort_req;
  assign sram_we      = wb_pop;
  assign wl_addr      = row_q;
  assign ib_pop       = (state_q == S_APPLY)  & ~ib_empty & ~abort_req;
  assign mac_starting = ib_pop;
  assign sa_sample    = (state_q == S_SAMPLE) & ~sa_full  & ~abort_req;
  assign irq          = (state_q == S_DONE)   & ~abort_req;
  assign en_vclp      = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                        (state_q == S_SAMPLE);
  assign ctrl_state   = state_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      2'd1:    rdata_d = {8'h0, cfg_vecs_q, 4'h0, cfg_settle_q, 3'h0, cfg_rows_q};
      2'd2:    rdata_d = {28'h0, abt_q, ign_q, done_q, state_q != S_IDLE};
      2'd3:    rdata_d = {16'h0, mac_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      vec_q        <= '0;
      settle_q     <= '0;
      rows_lim_q   <= '0;
      settle_lim_q <= '0;
      vecs_lim_q   <= '0;
      mac_q        <= '0;
      cfg_rows_q   <= '0;
      cfg_settle_q <= '0;
      cfg_vecs_q   <= '0;
      done_q       <= 1'b0;
      ign_q        <= 1'b0;
      abt_q        <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      ack_q <= wb_acc;
      dat_q <= (wb_acc && !wbs_we_i) ? rdata_d : '0;
      if (cfg_wr) begin
        cfg_rows_q   <= wbs_dat_i[4:0];
        cfg_settle_q <= wbs_dat_i[11:8];
        cfg_vecs_q   <= wbs_dat_i[23:16];
      end
      // W1C first so a same-edge set from the FSM below takes precedence.
      if (stat_wr) begin
        if (wbs_dat_i[1]) done_q <= 1'b0;
        if (wbs_dat_i[2]) ign_q  <= 1'b0;
        if (wbs_dat_i[3]) abt_q  <= 1'b0;
      end
      if (state_q == S_IDLE) begin
        if (abort_req) begin
          if (start_req) abt_q <= 1'b1;
        end else if (start_req) begin
          state_q      <= wbs_dat_i[1] ? S_APPLY : S_LOAD;
          row_q        <= '0;
          vec_q        <= '0;
          mac_q        <= '0;
          done_q       <= 1'b0;
          rows_lim_q   <= rows_use;
          settle_lim_q <= settle_use;
          vecs_lim_q   <= vecs_use;
        end
      end else if (abort_req) begin
        state_q  <= S_IDLE;
        abt_q    <= 1'b1;
        row_q    <= '0;
        settle_q <= '0;
      end else begin
        if (start_req) ign_q <= 1'b1;
        case (state_q)
          S_LOAD: begin
            if (wb_pop) begin
              if (last_row) begin
                row_q   <= '0;
                state_q <= S_APPLY;
              end else begin
                row_q <= row_q + AW'(1);
              end
            end
          end
          S_APPLY: begin
            if (ib_pop) begin
              settle_q <= settle_lim_q;
              state_q  <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_q <= 4'd1) state_q <= S_SAMPLE;
            else                  settle_q <= settle_q - 4'd1;
          end
          S_SAMPLE: begin
            if (sa_sample) begin
              mac_q <= mac_q + 16'd1;
              vec_q <= next_vec;
              if (more_vecs) begin
                state_q <= S_APPLY;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imc_mac_scheduler.sv
// Scoreboard bench for imc_mac_scheduler: directed runs push expected strobe events
// (with cycle offsets from the start write) and read data; a monitor pops and compares.
module tb_imc_mac_scheduler;
  localparam int ROWS = 16;
  localparam int AW   = 4;
  localparam int K_RD = 0, K_WP = 1, K_IP = 2, K_SS = 3, K_IRQ = 4;

  logic          wb_clk_i, wb_rst_i, wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic          wbs_ack_o;
  logic          wb_empty, ib_empty, sa_full;
  logic          wb_pop, ib_pop, sa_sample, sram_we;
  logic [AW-1:0] wl_addr;
  logic          en_vclp, mac_starting, irq;
  logic [2:0]    ctrl_state;

  typedef struct {
    int          kind;
    int          off;
    logic [31:0] val;
    string       nm;
  } ev_t;

  ev_t  q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  int   ws_lo = -100, ws_hi = -100, sf_lo = -100, sf_hi = -100;
  bit   rd_pending = 0;
  logic [2:0] st_ack;
  logic       en_ack;

  imc_mac_scheduler #(.ROWS(ROWS)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .wb_empty(wb_empty), .ib_empty(ib_empty), .sa_full(sa_full),
    .wb_pop(wb_pop), .ib_pop(ib_pop), .sa_sample(sa_sample),
    .sram_we(sram_we), .wl_addr(wl_addr), .en_vclp(en_vclp),
    .mac_starting(mac_starting), .ctrl_state(ctrl_state), .irq(irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Buffer flags as a function of the cycle offset from the last start write.
  initial begin
    wb_empty = 1'b0; ib_empty = 1'b0; sa_full = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      wb_empty = (cyc - t0 >= ws_lo) && (cyc - t0 <= ws_hi);
      sa_full  = (cyc - t0 >= sf_lo) && (cyc - t0 <= sf_hi);
    end
  end

  function automatic void push(int k, int off, logic [31:0] v, string nm);
    ev_t e;
    e.kind = k; e.off = off; e.val = v; e.nm = nm;
    q.push_back(e);
  endfunction

  task automatic check_ev(int k, logic [31:0] v, string what);
    ev_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got event at offset %0d, expected none", what, cyc - t0);
    end else begin
      e = q.pop_front();
      if (e.kind != k)
        begin n_fail++; $display("FAIL %s: got event %s, expected kind %0d", e.nm, what, e.kind); end
      else if (e.off >= 0 && (cyc - t0) != e.off)
        begin n_fail++; $display("FAIL %s: got offset %0d, expected %0d", e.nm, cyc - t0, e.off); end
      else if (v !== e.val)
        begin n_fail++; $display("FAIL %s: got 0x%08h, expected 0x%08h", e.nm, v, e.val); end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per output event, fixed order within a cycle.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i) begin
        if (wbs_ack_o && rd_pending) check_ev(K_RD, wbs_dat_o, "read");
        if (wb_pop)    check_ev(K_WP, 32'(wl_addr), "wb_pop");
        if (ib_pop)    check_ev(K_IP, 32'd0, "ib_pop");
        if (sa_sample) check_ev(K_SS, 32'd0, "sa_sample");
        if (irq)       check_ev(K_IRQ, 32'd0, "irq");
        if (wb_pop || sram_we) chk("sram_we_vs_wb_pop", {sram_we, wb_empty}, {wb_pop, 1'b0});
        if (ib_pop || mac_starting) chk("mac_start_vs_ib_pop", {mac_starting, ib_empty}, {ib_pop, 1'b0});
        if (sa_sample) chk("sa_sample_guard", {31'd0, sa_full}, 32'd0);
        if (en_vclp || (ctrl_state >= 3'd2 && ctrl_state <= 3'd4))
          chk("en_vclp_state", {31'd0, en_vclp}, {31'd0, ctrl_state >= 3'd2 && ctrl_state <= 3'd4});
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the ack cycle.
  task automatic wb_xfer(logic we, logic [3:0] adr, logic [31:0] d, bit mark);
    bit got = 0;
    if (mark) t0 = cyc + 1;
    wbs_adr_i = {28'h0, adr}; wbs_dat_i = d; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin got = 1; break; end
    end
    st_ack = ctrl_state;
    en_ack = en_vclp;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL ack_timeout: got no ack, expected ack within 4 cycles"); end
    @(posedge wb_clk_i);
    rd_pending = 0;
    @(negedge wb_clk_i);
  endtask

  task automatic wr(logic [3:0] adr, logic [31:0] d, bit mark);
    wb_xfer(1'b1, adr, d, mark);
  endtask

  task automatic rd(logic [3:0] adr, logic [31:0] exp, string nm);
    push(K_RD, -1, exp, nm);
    rd_pending = 1;
    wb_xfer(1'b0, adr, 32'd0, 1'b0);
  endtask

  task automatic drain(int max, string nm);
    for (int i = 0; i < max && q.size() != 0; i++) @(negedge wb_clk_i);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending events, expected 0", nm, q.size());
      q.delete();
    end
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic wait_off(int k);
    bit hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (cyc - t0 == k) begin hit = 1; break; end
      @(negedge wb_clk_i);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL wait_off: got no offset %0d, expected to reach it", k); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Reset state
    chk("rst_strobes", {25'd0, wb_pop, ib_pop, sa_sample, sram_we, en_vclp, mac_starting, irq}, 32'd0);
    chk("rst_state", {25'd0, ctrl_state, wl_addr}, 32'd0);
    chk("rst_wb", {wbs_dat_o[30:0], wbs_ack_o}, 32'd0);
    rd(4'h0, 32'h0, "rst_ctrl");
    rd(4'h4, 32'h0, "rst_cfg");
    rd(4'h8, 32'h0, "rst_status");
    rd(4'hC, 32'h0, "rst_maccount");

    // CFG keeps only its defined fields; CTRL reads zero
    wr(4'h4, 32'hFFFF_FFFF, 0);
    rd(4'h4, 32'h00FF_0F1F, "cfg_mask");
    rd(4'h0, 32'h0, "ctrl_reads0");

    // Basic run: 4 rows, settle 2, 2 vectors
    wr(4'h4, 32'h0002_0204, 0);
    for (int i = 0; i < 4; i++) push(K_WP, i, i, "basic_wp");
    push(K_IP, 4, 0, "basic_ip0");  push(K_SS, 7, 0, "basic_ss0");
    push(K_IP, 8, 0, "basic_ip1");  push(K_SS, 11, 0, "basic_ss1");
    push(K_IRQ, 12, 0, "basic_irq");
    wr(4'h0, 32'h1, 1);
    chk("basic_start_latency", {29'd0, st_ack}, 32'd1);
    drain(60, "basic");
    rd(4'hC, 32'd2, "basic_maccount");
    rd(4'h8, 32'h2, "basic_status");

    // Stalls: wb_empty for offsets 2..4, sa_full for 5 cycles at first SAMPLE
    ws_lo = 2; ws_hi = 4; sf_lo = 10; sf_hi = 14;
    push(K_WP, 0, 0, "stall_wp0"); push(K_WP, 1, 1, "stall_wp1");
    push(K_WP, 5, 2, "stall_wp2"); push(K_WP, 6, 3, "stall_wp3");
    push(K_IP, 7, 0, "stall_ip0");  push(K_SS, 15, 0, "stall_ss0");
    push(K_IP, 16, 0, "stall_ip1"); push(K_SS, 19, 0, "stall_ss1");
    push(K_IRQ, 20, 0, "stall_irq");
    wr(4'h0, 32'h1, 1);
    drain(80, "stall");
    ws_lo = -100; ws_hi = -100; sf_lo = -100; sf_hi = -100;
    rd(4'hC, 32'd2, "stall_maccount");

    // num_rows 0 clamps to ROWS
    wr(4'h4, 32'h0001_0100, 0);
    for (int i = 0; i < ROWS; i++) push(K_WP, i, i, "clamp_wp");
    push(K_IP, 16, 0, "clamp_ip"); push(K_SS, 18, 0, "clamp_ss");
    push(K_IRQ, 19, 0, "clamp_irq");
    wr(4'h0, 32'h1, 1);
    drain(80, "clamp");
    rd(4'h4, 32'h0001_0100, "clamp_cfg_raw");

    // skip_load with num_vecs 0: one vector, no weight pops
    wr(4'h4, 32'h0000_0204, 0);
    push(K_IP, 0, 0, "skip_ip"); push(K_SS, 3, 0, "skip_ss"); push(K_IRQ, 4, 0, "skip_irq");
    wr(4'h0, 32'h3, 1);
    chk("skip_state", {29'd0, st_ack}, 32'd2);
    drain(40, "skip");
    rd(4'hC, 32'd1, "skip_maccount");
    rd(4'h8, 32'h2, "skip_status");

    // Start ignored during SETTLE, W1C, then abort
    wr(4'h4, 32'h0001_0F04, 0);
    for (int i = 0; i < 4; i++) push(K_WP, i, i, "abort_wp");
    push(K_IP, 4, 0, "abort_ip");
    wr(4'h0, 32'h1, 1);
    wait_off(5);
    wr(4'h0, 32'h1, 0);
    rd(4'h8, 32'h5, "ignored_status");
    wr(4'h8, 32'h4, 0);
    rd(4'h8, 32'h1, "w1c_status");
    wr(4'h0, 32'h8, 0);
    chk("abort_state", {28'd0, en_ack, st_ack}, 32'd0);
    rd(4'h8, 32'h8, "aborted_status");
    repeat (12) @(negedge wb_clk_i);
    drain(1, "abort");

    // Reset during LOAD_W row 2
    wr(4'h4, 32'h0002_0204, 0);
    for (int i = 0; i < 3; i++) push(K_WP, i, i, "rst_mid_wp");
    wr(4'h0, 32'h1, 1);
    wait_off(2);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("midrst_strobes", {25'd0, wb_pop, ib_pop, sa_sample, sram_we, en_vclp, mac_starting, irq}, 32'd0);
    chk("midrst_state", {25'd0, ctrl_state, wl_addr}, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    rd(4'h4, 32'h0, "midrst_cfg");
    rd(4'h8, 32'h0, "midrst_status");
    wr(4'h4, 32'h0001_0102, 0);
    push(K_WP, 0, 0, "rerun_wp0"); push(K_WP, 1, 1, "rerun_wp1");
    push(K_IP, 2, 0, "rerun_ip"); push(K_SS, 4, 0, "rerun_ss"); push(K_IRQ, 5, 0, "rerun_irq");
    wr(4'h0, 32'h1, 1);
    drain(40, "rerun");
    rd(4'hC, 32'd1, "rerun_maccount");

    // Start and abort together in IDLE: abort wins
    wr(4'h0, 32'h9, 0);
    chk("start_abort_idle", {29'd0, st_ack}, 32'd0);
    rd(4'h8, 32'hA, "start_abort_status");
    drain(1, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
